uzorak_punjac: RTL and testbench
================================

UZORAK_PUNJAC -- requirements
Module: uzorak_punjac

Interface
REQ-001 Parameter WORD_W, default 16: width of one incoming sample word and of the result.
REQ-002 Parameter N_WORDS, default 60: words per sample; sample width = WORD_W*N_WORDS = 960.
REQ-003 Parameter SETTLE, default 2, legal range 1..15: clock cycles allowed for the external neuron to settle after a sample is complete.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_podatak  input  WORD_W  incoming sample word.
REQ-007 s_valid  input  1  s_podatak is valid.
REQ-008 s_ready  output  1  block accepts a word this cycle.
REQ-009 uzorak  output  WORD_W*N_WORDS  assembled sample, wired to the neuron's uzorak input.
REQ-010 izlaz  input  WORD_W  neuron probability output.
REQ-011 m_vjerojatnost  output  WORD_W  captured probability.
REQ-012 m_valid  output  1  m_vjerojatnost is valid.
REQ-013 m_ready  input  1  downstream accepts the result.
REQ-014 greska  output  1  sticky flag: a word was offered while the block was not accepting.

Function
REQ-015 FSM states SHALL be PRIMI (receive), CEKAJ (settle), PREDAJ (present); reset state PRIMI.
REQ-016 s_ready SHALL be 1 exactly in PRIMI; a word is accepted on a cycle with s_valid=1 and s_ready=1.
REQ-017 Word k (0-based, in acceptance order) SHALL be written to uzorak bits [WORD_W*(N_WORDS-k)-1 : WORD_W*(N_WORDS-k-1)]; the first word occupies the MSBs.
REQ-018 The word counter SHALL increment on each accept and SHALL never exceed N_WORDS-1; the accept of word N_WORDS-1 SHALL clear the counter and move to CEKAJ on the same edge.
REQ-019 uzorak SHALL hold its contents outside PRIMI and SHALL be overwritten only word-by-word during PRIMI; bits not yet rewritten keep the previous sample.
REQ-020 In CEKAJ a settle counter SHALL count SETTLE cycles; on the last one, izlaz SHALL be captured into m_vjerojatnost and the state SHALL become PREDAJ.
REQ-021 Latency: m_valid SHALL rise exactly SETTLE+1 rising edges after the edge that accepted the last word.
REQ-022 In PREDAJ m_valid=1 and m_vjerojatnost SHALL stay stable until m_ready=1; on the accept edge m_valid drops and the state returns to PRIMI.
REQ-023 s_ready SHALL be 0 in the PREDAJ accept cycle; the earliest next word accept is the following cycle.
REQ-024 s_valid=1 while the state is CEKAJ or PREDAJ SHALL set greska to 1; the word is not accepted and greska stays 1 until reset.
REQ-025 m_ready while m_valid=0 SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force: state PRIMI, both counters 0, uzorak all 0, m_vjerojatnost 0, m_valid 0, greska 0; s_ready becomes 1 only after rst_n deasserts.
REQ-027 Reset asserted mid-sample or mid-settle SHALL discard the partial sample; the next accepted word is treated as word 0.

Structure
REQ-028 A shared package uzorak_pkg SHALL hold WORD_W, N_WORDS, the SETTLE default and the state encoding constants; neuron-side modules reuse WORD_W and N_WORDS from it.
REQ-029 The block SHALL NOT instantiate neuron_1_FL; the neuron is connected at the next level up.
REQ-030 One sub-module, uzorak_brojac (parameterised wrap counter with terminal-count output), is natural and SHALL serve both the word and the settle counters.

Verification
REQ-031 After reset, send 60 words 0x0001..0x003C back-to-back -> uzorak[959:944]=0x0001, uzorak[15:0]=0x003C, s_ready=0 the cycle after the last accept.
REQ-032 Stub neuron driving izlaz=0x7A3F, SETTLE=2 -> m_valid rises 3 edges after the last accept, with m_vjerojatnost=0x7A3F.
REQ-033 Hold m_ready=0 for 10 cycles while izlaz changes to 0x1111 -> m_vjerojatnost stays 0x7A3F; m_ready=1 -> m_valid=0 next edge, s_ready=1.
REQ-034 s_valid asserted during CEKAJ with 0xDEAD -> word not taken, greska=1 until reset, uzorak unchanged.
REQ-035 rst_n pulsed low after 30 words, then 60 words 0xFFFF -> uzorak all 1s, m_valid fires normally, greska=0.
REQ-036 s_valid toggled randomly (50%) over two samples -> words land in order, exactly two results delivered.

Source files
------------

// File: rtl/uzorak_pkg.sv
// uzorak_pkg: shared sizes and FSM state codes for the sample
// loader and the neuron-side modules that reuse WORD_W/N_WORDS.
package uzorak_pkg;
  localparam int WORD_W     = 16;
  localparam int N_WORDS    = 60;
  localparam int SETTLE_DEF = 2;

  localparam logic [1:0] ST_PRIMI  = 2'd0;
  localparam logic [1:0] ST_CEKAJ  = 2'd1;
  localparam logic [1:0] ST_PREDAJ = 2'd2;
endpackage

// File: rtl/uzorak_brojac.sv
// uzorak_brojac: wrap counter 0..MAX-1 with terminal-count flag.
// Ports: clk, rst_n (async low), en, cnt (value), tc (cnt==MAX-1).
module uzorak_brojac #(
  parameter int MAX = 60,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == W'(MAX - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uzorak_punjac.sv
// uzorak_punjac: packs N_WORDS stream words into one sample, waits
// for the neuron to settle, then hands its probability downstream.
// Ports: s_* word input, uzorak to neuron, izlaz from neuron,
//        m_* result output, greska sticky protocol-error flag.
module uzorak_punjac #(
  parameter int WORD_W  = uzorak_pkg::WORD_W,
  parameter int N_WORDS = uzorak_pkg::N_WORDS,
  parameter int SETTLE  = uzorak_pkg::SETTLE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_W-1:0]         s_podatak,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [WORD_W*N_WORDS-1:0] uzorak,
  input  logic [WORD_W-1:0]         izlaz,
  output logic [WORD_W-1:0]         m_vjerojatnost,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      greska
);
  import uzorak_pkg::*;

  localparam int WC_W = $clog2(N_WORDS);
  localparam int SC_W = $clog2(SETTLE + 1);

  logic [1:0]                state_q, state_d;
  logic [WORD_W*N_WORDS-1:0] uzorak_q, uzorak_d;
  logic [WORD_W-1:0]         vjer_q, vjer_d;
  logic                      greska_q, greska_d;

  logic [WC_W-1:0] wcnt;
  logic            wtc;
  logic [SC_W-1:0] settle_cnt_unused;
  logic            stc;

  logic st_primi, st_cekaj, st_predaj;
  logic acc;

  assign st_primi  = (state_q == ST_PRIMI);
  assign st_cekaj  = (state_q == ST_CEKAJ);
  assign st_predaj = (state_q == ST_PREDAJ);

  // Held low while reset is applied, not just while in PRIMI.
  assign s_ready = st_primi & rst_n;
  assign acc     = s_valid & s_ready;

  uzorak_brojac #(
    .MAX (N_WORDS),
    .W   (WC_W)
  ) u_word (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .cnt   (wcnt),
    .tc    (wtc)
  );

  // Counts SETTLE+1 states including the entry edge, so m_valid
  // appears SETTLE+1 edges after the last word is taken.
  uzorak_brojac #(
    .MAX (SETTLE + 1),
    .W   (SC_W)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (st_cekaj),
    .cnt   (settle_cnt_unused),
    .tc    (stc)
  );

  always_comb begin
    uzorak_d = uzorak_q;
    for (int k = 0; k < N_WORDS; k++) begin
      if (acc && wcnt == WC_W'(k))
        uzorak_d[WORD_W*(N_WORDS-1-k) +: WORD_W] = s_podatak;
    end
  end

  always_comb begin
    state_d  = state_q;
    vjer_d   = vjer_q;
    greska_d = greska_q | (s_valid & ~st_primi);
    unique case (1'b1)
      st_primi: begin
        if (acc && wtc) state_d = ST_CEKAJ;
      end
      st_cekaj: begin
        if (stc) begin
          vjer_d  = izlaz;
          state_d = ST_PREDAJ;
        end
      end
      st_predaj: begin
        if (m_ready) state_d = ST_PRIMI;
      end
      default: state_d = ST_PRIMI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PRIMI;
      uzorak_q <= '0;
      vjer_q   <= '0;
      greska_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      uzorak_q <= uzorak_d;
      vjer_q   <= vjer_d;
      greska_q <= greska_d;
    end
  end

  assign uzorak         = uzorak_q;
  assign m_vjerojatnost = vjer_q;
  assign m_valid        = st_predaj;
  assign greska         = greska_q;
endmodule

// File: tb/tb_uzorak_punjac.sv
// tb_uzorak_punjac: table vectors, corner sequences and random
// valid toggling checked against a word-array sample model.
module tb_uzorak_punjac;
  import uzorak_pkg::*;

  localparam int W  = WORD_W;
  localparam int N  = N_WORDS;
  localparam int ST = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   s_podatak;
  logic           s_valid;
  logic           s_ready;
  logic [W*N-1:0] uzorak;
  logic [W-1:0]   izlaz;
  logic [W-1:0]   m_vjerojatnost;
  logic           m_valid;
  logic           m_ready;
  logic           greska;

  uzorak_punjac #(
    .WORD_W  (W),
    .N_WORDS (N),
    .SETTLE  (ST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_podatak      (s_podatak),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .uzorak         (uzorak),
    .izlaz          (izlaz),
    .m_vjerojatnost (m_vjerojatnost),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .greska         (greska)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_res = 0;

  logic [W-1:0] mdl [N];
  int           mdl_k;
  logic         exp_greska;

  always @(posedge clk)
    if (rst_n && m_valid && m_ready) n_res++;

  typedef struct {
    logic [W-1:0] start;
    logic [W-1:0] stp;
    logic [W-1:0] izl;
    logic [W-1:0] first;
    logic [W-1:0] last;
    bit           poke;
  } vec_t;

  vec_t tv [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int k = 0; k < N; k++) mdl[k] = '0;
    mdl_k = 0;
  endtask

  task automatic chk_uz(input string nm);
    logic [W*N-1:0] e;
    int             bk;
    for (int k = 0; k < N; k++) e[W*(N-1-k) +: W] = mdl[k];
    total++;
    if (uzorak !== e) begin
      bad++;
      bk = 0;
      for (int k = N - 1; k >= 0; k--)
        if (uzorak[W*(N-1-k) +: W] !== e[W*(N-1-k) +: W]) bk = k;
      $display("FAIL %s word=%0d got=%h exp=%h", nm, bk,
               uzorak[W*(N-1-bk) +: W], e[W*(N-1-bk) +: W]);
    end
  endtask

  task automatic put(input logic [W-1:0] d);
    s_valid   = 1'b1;
    s_podatak = d;
    chk("s_ready_acc", s_ready, 1'b1);
    step();
    s_valid   = 1'b0;
    mdl[mdl_k] = d;
    mdl_k = (mdl_k + 1) % N;
  endtask

  task automatic send(input logic [W-1:0] start,
                      input logic [W-1:0] stp, input int cnt);
    logic [W-1:0] d;
    for (int i = 0; i < cnt; i++) begin
      d = start + W'(i) * stp;
      put(d);
    end
  endtask

  task automatic get_result(input logic [W-1:0] izl, input bit poke);
    int n;
    izlaz = izl;
    n = 0;
    if (poke) begin
      s_valid   = 1'b1;
      s_podatak = 16'hDEAD;
      step();
      s_valid    = 1'b0;
      exp_greska = 1'b1;
      n = 1;
      chk("greska_set", greska, 1'b1);
    end
    while (!m_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, ST + 1);
    chk("result", m_vjerojatnost, izl);
    izlaz = 16'h1111;
    repeat (10) step();
    chk("hold_valid", m_valid, 1'b1);
    chk("hold_result", m_vjerojatnost, izl);
    chk("ready_in_predaj", s_ready, 1'b0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("valid_drop", m_valid, 1'b0);
    chk("ready_back", s_ready, 1'b1);
    chk("greska", greska, exp_greska);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n0, cyc, acc_n;
    logic [W-1:0] izl;
    bit v;

    tv[0] = '{16'h0001, 16'h0001, 16'h7A3F, 16'h0001, 16'h003C, 1'b0};
    tv[1] = '{16'h1234, 16'h0002, 16'h0F0F, 16'h1234, 16'h12AA, 1'b0};
    tv[2] = '{16'h8000, 16'h0101, 16'hBEEF, 16'h8000, 16'hBB3B, 1'b1};

    rst_n = 1'b0; s_valid = 1'b0; s_podatak = '0;
    m_ready = 1'b0; izlaz = '0;
    mdl_clear();
    exp_greska = 1'b0;
    repeat (2) step();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_greska", greska, 1'b0);
    chk("rst_result", m_vjerojatnost, '0);
    chk_uz("rst_uzorak");
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", s_ready, 1'b1);
    step();

    m_ready = 1'b1;
    repeat (3) step();
    chk("idle_mready_valid", m_valid, 1'b0);
    chk("idle_mready_ready", s_ready, 1'b1);
    m_ready = 1'b0;

    for (int t = 0; t < 3; t++) begin
      send(tv[t].start, tv[t].stp, N);
      chk("ready_after_last", s_ready, 1'b0);
      chk("first_word", uzorak[W*N-1 -: W], tv[t].first);
      chk("last_word", uzorak[W-1:0], tv[t].last);
      chk_uz("uzorak_vec");
      get_result(tv[t].izl, tv[t].poke);
      chk_uz("uzorak_held");
    end

    send(16'h5A00, 16'h0001, 30);
    chk_uz("partial_overwrite");
    rst_n = 1'b0;
    #1;
    mdl_clear();
    exp_greska = 1'b0;
    chk_uz("midrst_uzorak");
    chk("midrst_greska", greska, 1'b0);
    chk("midrst_ready", s_ready, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    send(16'hFFFF, 16'h0000, N);
    chk("all_ones", &uzorak, 1'b1);
    chk_uz("ones_uzorak");
    get_result(16'h4C4C, 1'b0);

    n0 = n_res;
    for (int s = 0; s < 2; s++) begin
      izl = W'($urandom);
      acc_n = 0;
      cyc = 0;
      while (acc_n < N && cyc < 2000) begin
        v = 1'($urandom % 2);
        s_valid = v;
        s_podatak = W'($urandom);
        if (v) chk("rnd_ready", s_ready, 1'b1);
        step();
        if (v) begin
          mdl[mdl_k] = s_podatak;
          mdl_k = (mdl_k + 1) % N;
          acc_n++;
        end
        s_valid = 1'b0;
        cyc++;
      end
      chk("rnd_words", acc_n, N);
      chk_uz("rnd_uzorak");
      get_result(izl, 1'b0);
    end
    chk("rnd_results", n_res - n0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
